// File: rtl/bsg_downstream_pkg.sv
// rtl/bsg_downstream_pkg.sv - shared types and sizing helpers for the downstream reassembler
package bsg_downstream_pkg;

  typedef enum logic {
    ASSEMBLE = 1'b0,
    PRESENT  = 1'b1
  } state_e;

  // Pointer width: index bits plus one wrap bit to tell full from empty.
  function automatic int ptr_w_f(input int depth);
    return $clog2(depth) + 1;
  endfunction

  // Pointer bit that flips once every TOKEN_DEC reads.
  function automatic int tok_bit_f(input int token_dec);
    return $clog2(token_dec);
  endfunction

endpackage

// File: rtl/bsg_downstream_mem.sv
// rtl/bsg_downstream_mem.sv - beat storage array, one sync write port and one async read port
module bsg_downstream_mem #(
  parameter int IO_W  = 16,
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [IO_W-1:0] wr_data,
  input  logic [AW-1:0]   rd_addr,
  output logic [IO_W-1:0] rd_data
);

  logic [IO_W-1:0] mem_q [DEPTH];

  // Contents are deliberately not reset; the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/bsg_downstream_reassembler.sv
// rtl/bsg_downstream_reassembler.sv - circular beat buffer that reassembles beats into core words
module bsg_downstream_reassembler
  import bsg_downstream_pkg::*;
#(
  parameter int IO_W      = 16,
  parameter int BEATS     = 2,
  parameter int DEPTH     = 64,
  parameter int TOKEN_DEC = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  io_valid_in,
  input  logic [IO_W-1:0]       io_data_in,
  output logic                  io_token_out,
  output logic                  core_valid_out,
  output logic [IO_W*BEATS-1:0] core_data_out,
  input  logic                  core_ready,
  output logic                  full,
  output logic                  overflow
);

  localparam int AW      = $clog2(DEPTH);
  localparam int PTR_W   = ptr_w_f(DEPTH);
  localparam int TOK_BIT = tok_bit_f(TOKEN_DEC);
  localparam int W       = IO_W * BEATS;
  localparam int CNT_W   = 3;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  state_e           state_q, state_d;
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [PTR_W-1:0] rptr_inc;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic             valid_q, valid_d;
  logic [W-1:0]     data_q, data_d;
  logic             token_q, token_d;
  logic             overflow_q, overflow_d;
  logic             empty;
  logic             wr_en;
  logic [IO_W-1:0]  rd_data;

  assign empty    = (wptr_q == rptr_q);
  assign full     = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
  assign rptr_inc = rptr_q + PTR_W'(1);

  bsg_downstream_mem #(
    .IO_W  (IO_W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wptr_q[AW-1:0]),
    .wr_data (io_data_in),
    .rd_addr (rptr_q[AW-1:0]),
    .rd_data (rd_data)
  );

  // Write side: accept a beat unless full; a beat arriving while full is lost and flagged.
  always_comb begin
    wr_en      = 1'b0;
    wptr_d     = wptr_q;
    overflow_d = overflow_q;
    if (io_valid_in) begin
      if (full) begin
        overflow_d = 1'b1;
      end else begin
        wr_en  = 1'b1;
        wptr_d = wptr_q + PTR_W'(1);
      end
    end
  end

  // Read FSM: pull one beat per cycle into the word slice, then hold the word until accepted.
  always_comb begin
    state_d    = state_q;
    rptr_d     = rptr_q;
    beat_cnt_d = beat_cnt_q;
    valid_d    = valid_q;
    data_d     = data_q;
    token_d    = token_q;
    unique case (state_q)
      ASSEMBLE: begin
        if (!empty) begin
          for (int k = 0; k < BEATS; k++) begin
            if (beat_cnt_q == CNT_W'(k)) begin
              data_d[k*IO_W +: IO_W] = rd_data;
            end
          end
          rptr_d  = rptr_inc;
          token_d = rptr_inc[TOK_BIT];
          if (beat_cnt_q == LAST_BEAT) begin
            beat_cnt_d = '0;
            state_d    = PRESENT;
            valid_d    = 1'b1;
          end else begin
            beat_cnt_d = beat_cnt_q + CNT_W'(1);
          end
        end
      end
      PRESENT: begin
        if (core_ready) begin
          state_d = ASSEMBLE;
          valid_d = 1'b0;
        end
      end
      default: begin
        state_d = ASSEMBLE;
      end
    endcase
  end

  // State registers; reset abandons any partial or presented word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ASSEMBLE;
      wptr_q     <= '0;
      rptr_q     <= '0;
      beat_cnt_q <= '0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      token_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      beat_cnt_q <= beat_cnt_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      token_q    <= token_d;
      overflow_q <= overflow_d;
    end
  end

  assign core_valid_out = valid_q;
  assign core_data_out  = data_q;
  assign io_token_out   = token_q;
  assign overflow       = overflow_q;

endmodule

// File: tb/tb_bsg_downstream_reassembler.sv
// tb/tb_bsg_downstream_reassembler.sv - randomized bench with a queue-based reference model
module tb_bsg_downstream_reassembler;

  localparam int IO_W      = 16;
  localparam int BEATS     = 2;
  localparam int DEPTH     = 64;
  localparam int TOKEN_DEC = 8;
  localparam int W         = IO_W * BEATS;

  logic            clk = 1'b0;
  logic            rst;
  logic            io_valid_in;
  logic [IO_W-1:0] io_data_in;
  logic            io_token_out;
  logic            core_valid_out;
  logic [W-1:0]    core_data_out;
  logic            core_ready;
  logic            full;
  logic            overflow;

  bsg_downstream_reassembler #(
    .IO_W      (IO_W),
    .BEATS     (BEATS),
    .DEPTH     (DEPTH),
    .TOKEN_DEC (TOKEN_DEC)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .io_valid_in    (io_valid_in),
    .io_data_in     (io_data_in),
    .io_token_out   (io_token_out),
    .core_valid_out (core_valid_out),
    .core_data_out  (core_data_out),
    .core_ready     (core_ready),
    .full           (full),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: buffer as a queue, plus the word being built or presented.
  logic [IO_W-1:0] m_fifo[$];
  logic [IO_W-1:0] sb[$];
  logic [W-1:0]    m_word;
  int              m_nb;
  bit              m_present;
  bit              m_token;
  bit              m_ovf;
  int              m_reads;

  task automatic step(input bit v, input logic [IO_W-1:0] d, input bit rdy, input bit r);
    bit           was_full;
    bit           was_empty;
    logic [W-1:0] exp_w;
    rst         = r;
    io_valid_in = v;
    io_data_in  = d;
    core_ready  = rdy;
    if (r) begin
      m_fifo.delete();
      sb.delete();
      m_word    = '0;
      m_nb      = 0;
      m_present = 0;
      m_token   = 0;
      m_ovf     = 0;
      m_reads   = 0;
    end else begin
      was_full  = (m_fifo.size() == DEPTH);
      was_empty = (m_fifo.size() == 0);
      if (m_present) begin
        if (rdy) begin
          exp_w = '0;
          for (int k = 0; k < BEATS; k++) exp_w[k*IO_W +: IO_W] = sb.pop_front();
          check_val("xfer_word", core_data_out, exp_w);
          m_present = 0;
        end
      end else if (!was_empty) begin
        m_word[m_nb*IO_W +: IO_W] = m_fifo.pop_front();
        m_nb++;
        m_reads++;
        m_token = ((m_reads / TOKEN_DEC) % 2) == 1;
        if (m_nb == BEATS) begin
          m_nb      = 0;
          m_present = 1;
        end
      end
      if (v) begin
        if (was_full) m_ovf = 1;
        else begin
          m_fifo.push_back(d);
          sb.push_back(d);
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    check_val("valid", core_valid_out, m_present);
    check_val("data", core_data_out, m_word);
    check_val("token", io_token_out, m_token);
    check_val("full", full, m_fifo.size() == DEPTH);
    check_val("overflow", overflow, m_ovf);
  endtask

  initial begin
    int  full_at;
    int  toggles;
    bit  prev_tok;
    rst         = 1'b1;
    io_valid_in = 1'b0;
    io_data_in  = '0;
    core_ready  = 1'b0;

    // Reset state
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    check_val("rst_valid", core_valid_out, 0);
    check_val("rst_data", core_data_out, 0);
    check_val("rst_token", io_token_out, 0);
    check_val("rst_full", full, 0);
    check_val("rst_ovf", overflow, 0);

    // Basic reassembly: word presented BEATS+1 cycles after first beat, for one cycle
    step(1, 16'h1111, 1, 0);
    step(1, 16'h2222, 1, 0);
    check_val("reasm_early", core_valid_out, 0);
    step(0, 0, 1, 0);
    check_val("reasm_valid", core_valid_out, 1);
    check_val("reasm_data", core_data_out, 32'h2222_1111);
    step(0, 0, 1, 0);
    check_val("reasm_drop", core_valid_out, 0);

    // Backpressure: first word held for 10 cycles, second word follows release
    step(0, 0, 0, 1);
    step(1, 16'hA001, 0, 0);
    step(1, 16'hA002, 0, 0);
    step(1, 16'hA003, 0, 0);
    step(1, 16'hA004, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 0);
      check_val("bp_hold_v", core_valid_out, 1);
      check_val("bp_hold_d", core_data_out, 32'hA002_A001);
    end
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    check_val("bp_word2_v", core_valid_out, 1);
    check_val("bp_word2_d", core_data_out, 32'hA004_A003);
    step(0, 0, 1, 0);

    // Fill to full with core stalled, then overflow
    step(0, 0, 0, 1);
    full_at = -1;
    for (int i = 1; i <= DEPTH + BEATS + 4; i++) begin
      step(1, IO_W'($urandom), 0, 0);
      if (full && full_at < 0) full_at = i;
    end
    check_val("fill_full_at", full_at, DEPTH + BEATS);
    check_val("fill_full", full, 1);
    check_val("fill_ovf", overflow, 1);
    for (int i = 0; i < 3 * DEPTH; i++) step(0, 0, 1, 0);
    check_val("fill_drained", full, 0);
    check_val("fill_ovf_sticky", overflow, 1);

    // Token: 16 streamed beats give two toggles
    step(0, 0, 0, 1);
    toggles  = 0;
    prev_tok = io_token_out;
    for (int i = 0; i < 2 * TOKEN_DEC + 12; i++) begin
      step(i < 2 * TOKEN_DEC, IO_W'($urandom), 1, 0);
      if (io_token_out != prev_tok) toggles++;
      prev_tok = io_token_out;
    end
    check_val("tok_toggles", toggles, 2);
    check_val("tok_final", io_token_out, 0);

    // Random traffic with pointer wrap
    step(0, 0, 0, 1);
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 9) < 4, IO_W'($urandom), $urandom_range(0, 3) != 0, 0);
    end
    for (int i = 0; i < 3 * DEPTH; i++) step(0, 0, 1, 0);
    check_val("wrap_idle_v", core_valid_out, 0);

    // Reset mid-word, then a clean word
    step(1, 16'hAAAA, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 1);
    check_val("mid_rst_valid", core_valid_out, 0);
    check_val("mid_rst_data", core_data_out, 0);
    check_val("mid_rst_token", io_token_out, 0);
    check_val("mid_rst_full", full, 0);
    check_val("mid_rst_ovf", overflow, 0);
    step(1, 16'h3333, 1, 0);
    step(1, 16'h4444, 1, 0);
    step(0, 0, 1, 0);
    check_val("clean_valid", core_valid_out, 1);
    check_val("clean_data", core_data_out, 32'h4444_3333);
    step(0, 0, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
